// File: rtl/digest_serializer.sv
// digest_serializer
//
// Captures a finished digest on a one-cycle strobe and hands it to a UART
// transmitter one symbol at a time, most-significant symbol first. Each
// symbol goes out with a one-cycle Tx_DV_out strobe. The next symbol waits
// for the transmitter's Tx_Done_in pulse. done_out marks the end of a digest.
//
// Build option: define DIGEST_ASCII_HEX_EN to emit each digest byte as two
// lowercase ASCII hex characters, high nibble first. Without it, raw bytes
// are emitted.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   digest_in     finished digest, big-endian (top byte sent first)
//   digest_dv_in  one-cycle capture strobe for digest_in
//   Tx_Active_in  transmitter busy shifting a frame
//   Tx_Done_in    one-cycle end-of-frame pulse from the transmitter
//   Tx_DV_out     one-cycle strobe, Tx_Byte_out valid
//   Tx_Byte_out   symbol handed to the transmitter
//   busy_out      high from capture until done_out
//   done_out      one-cycle pulse after the last frame completes
//   drop_out      one-cycle pulse when a digest arrives while not idle
module digest_serializer #(
    parameter int unsigned DIGEST_BYTES = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [8*DIGEST_BYTES-1:0] digest_in,
    input  logic                      digest_dv_in,
    input  logic                      Tx_Active_in,
    input  logic                      Tx_Done_in,
    output logic                      Tx_DV_out,
    output logic [7:0]                Tx_Byte_out,
    output logic                      busy_out,
    output logic                      done_out,
    output logic                      drop_out
);

    localparam int unsigned DW = 8 * DIGEST_BYTES;
`ifdef DIGEST_ASCII_HEX_EN
    localparam int unsigned SYM_W = 4;
    localparam int unsigned NSYM  = 2 * DIGEST_BYTES;
`else
    localparam int unsigned SYM_W = 8;
    localparam int unsigned NSYM  = DIGEST_BYTES;
`endif
    localparam int unsigned CNT_W = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NSYM - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEND   = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [DW-1:0]    shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tx_dv_q;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             drop_q, drop_d;
    logic             issue;
    logic [7:0]       sym_byte;
`ifdef DIGEST_ASCII_HEX_EN
    logic [3:0]       nib;
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        issue   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (digest_dv_in) begin
                    shreg_d = digest_in;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SEND;
                    issue   = !Tx_Active_in;
                end
            end
            S_SEND: begin
                issue = !Tx_Active_in;
            end
            S_WAIT: begin
                if (Tx_Done_in) begin
                    if (cnt_q == LAST_IDX) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        shreg_d = shreg_q << SYM_W;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_SEND;
                        issue   = !Tx_Active_in;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The strobe is registered on the same edge that selects the symbol,
        // so the symbol comes from the next-state shift register.
        if (issue) begin
            state_d = S_WAIT;
        end

`ifdef DIGEST_ASCII_HEX_EN
        nib      = shreg_d[DW-1 -: 4];
        sym_byte = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
`else
        sym_byte = shreg_d[DW-1 -: 8];
`endif
        tx_byte_d = issue ? sym_byte : tx_byte_q;
        drop_d    = digest_dv_in && (state_q != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            tx_dv_q   <= issue;
            tx_byte_q <= tx_byte_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            drop_q    <= drop_d;
        end
    end

    assign Tx_DV_out   = tx_dv_q;
    assign Tx_Byte_out = tx_byte_q;
    assign busy_out    = busy_q;
    assign done_out    = done_q;
    assign drop_out    = drop_q;

endmodule
